block_streamer: RTL and testbench
=================================

# block_streamer

Drain stage behind the block buffer. It waits until the buffer reports full, then walks the buffer's random-access read port from address 0 to LEN-1 and presents each word on a valid/ready stream. After the last word is accepted it pulses the buffer's clear input so the next block can be captured. It sits between the capture block buffer and the downstream stream consumer.

## Interface
- LEN, 8 — words per block; power of two, ≥ 2.
- WID, 8 — data width in bits.
- ADDR_WID, $clog2(LEN) — read-pointer width; derived, not overridden.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- buf_ready  input  1  buffer status: high = accepting writes, low = full.
- buf_data  input  WID  buffer read data; combinational from rd_ptr.
- rd_ptr  output  ADDR_WID  buffer read address.
- buf_clear  output  1  one-cycle pulse wired to the buffer's synchronous reset.
- out_data  output  WID  stream data.
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  marks the final word of a block.
- busy  output  1  high in any state other than IDLE.
- block_cnt  output  16  count of completed blocks; wraps at 2^16.

## Operation
- States: IDLE, STREAM, SUM (only with the macro defined), CLEAR. All outputs are Moore outputs of state and registers; out_data additionally follows buf_data.
- Reset values: state = IDLE, rd_ptr = 0, sum = 0, block_cnt = 0, out_valid = 0, out_last = 0, buf_clear = 0, busy = 0. out_data = 0 while out_valid = 0.
- IDLE:
  - rd_ptr holds 0.
  - If buf_ready = 0 at a clock edge, go to STREAM.
- STREAM:
  - out_valid = 1; out_data = buf_data.
  - A handshake occurs when out_valid and out_ready are both high. On a handshake with rd_ptr < LEN-1, rd_ptr increments by 1.
  - On a handshake with rd_ptr = LEN-1:
    - rd_ptr returns to 0.
    - Next state is SUM if the macro is defined, otherwise CLEAR.
  - With no handshake, rd_ptr and out_data hold stable. Valid is never withdrawn.
- out_last = 1 in STREAM at rd_ptr = LEN-1 when the macro is undefined, and in SUM when it is defined. Otherwise out_last = 0.
- CLEAR:
  - buf_clear = 1 for exactly one cycle; out_valid = 0.
  - block_cnt increments.
  - Next state is IDLE unconditionally.
- The buffer sees the clear at the same edge that leaves CLEAR, so buf_ready is high again in the following IDLE cycle. This prevents a spurious retrigger.
- buf_ready rising during STREAM (external reset of the buffer) is ignored; streaming completes.
- Reset mid-block returns to IDLE without pulsing buf_clear. If the buffer is still full, the block restarts from word 0.

## Timing
- buf_ready sampled low at edge T puts the block in STREAM from T; word 0 is valid in the cycle after edge T.
- With out_ready held high:
  - Word k is presented in cycle k.
  - CLEAR follows in cycle LEN (cycle LEN+1 with the macro).
  - IDLE follows in the next cycle.
  - Block overhead is 2 cycles beyond the data words (3 with the macro).
- out_ready may toggle arbitrarily. Each stall cycle adds exactly one cycle of latency.
- There is no combinational path from out_ready to out_valid or out_data.

## Configuration
- STREAM_CHECKSUM_EN defined:
  - sum accumulates (sum + word) mod 2^WID on every STREAM handshake; it is cleared in IDLE.
  - After word LEN-1, SUM presents one extra word with out_data = sum, out_valid = 1, out_last = 1, and holds it until a handshake, then goes to CLEAR.
  - A block is LEN+1 stream words.
- STREAM_CHECKSUM_EN undefined: no sum register and no SUM state. A block is LEN stream words, with out_last on word LEN-1.

## Test plan
- Reset, buf_ready = 1 for 20 cycles -> out_valid = 0, busy = 0, rd_ptr = 0, buf_clear never asserted.
- LEN = 8, buffer filled with 0x10..0x17, out_ready = 1 -> words 0x10..0x17 on 8 consecutive cycles; out_last only on 0x17; buf_clear pulses once, one cycle after 0x17; block_cnt = 1.
- Same block, out_ready low on every other cycle -> identical word sequence; data is stable during each stall; the block completes in 16 cycles.
- Reset asserted after word 3 with the buffer still full -> no buf_clear; after reset, the stream restarts at 0x10.
- Macro defined, words 0xFF, 0x02, 0, 0, 0, 0, 0, 0 -> ninth word 0x01 with out_last = 1; then buf_clear; on the second block, sum starts from 0.
- Two back-to-back full blocks -> exactly one IDLE cycle between the buf_clear pulse and the next STREAM entry; block_cnt = 2.

Source files
------------

// File: rtl/block_streamer_if.sv
// ---------------------------------------------------------------------------
// block_streamer_if
//   Valid/ready word stream leaving the block streamer.
//
//   Handshake: a word transfers on a rising clk edge where out_valid and
//   out_ready are both high. Once out_valid is raised, the master holds it
//   high and keeps out_data/out_last stable until that transfer happens.
//   out_ready may change freely; the master never feeds it combinationally
//   back into out_valid or out_data.
//
//   Signals
//     out_data  [WID-1:0]  word being presented
//     out_valid            word is valid
//     out_ready            consumer accepts the word
//     out_last             word is the final one of the block
//
//   Modports: master (block_streamer), slave (stream consumer).
// ---------------------------------------------------------------------------
interface block_streamer_if #(
  parameter int WID = 8
);
  logic [WID-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/block_streamer.sv
// ---------------------------------------------------------------------------
// block_streamer
//   Drain stage behind the capture block buffer. Waits for the buffer to
//   report full (buf_ready low), walks its read port from address 0 to LEN-1
//   presenting each word on the stream interface, then pulses buf_clear for
//   one cycle so the next block can be captured.
//
//   Optional feature macro: STREAM_CHECKSUM_EN
//     When defined, a running (sum of words) mod 2^WID is sent as one extra
//     word after word LEN-1, and that word carries out_last.
//
//   Ports
//     clk        clock
//     reset      synchronous, active-high reset
//     buf_ready  buffer status: 1 = accepting writes, 0 = full
//     buf_data   buffer read data, combinational from rd_ptr
//     rd_ptr     buffer read address
//     buf_clear  one-cycle pulse to the buffer's synchronous reset
//     strm       stream interface (master): out_data/out_valid/out_last/out_ready
//     busy       high whenever the FSM is not IDLE
//     block_cnt  completed blocks, wraps at 2^16
//     dbg_state  current FSM state
// ---------------------------------------------------------------------------
module block_streamer #(
  parameter  int LEN      = 8,
  parameter  int WID      = 8,
  localparam int ADDR_WID = $clog2(LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                buf_ready,
  input  logic [WID-1:0]      buf_data,
  output logic [ADDR_WID-1:0] rd_ptr,
  output logic                buf_clear,
  block_streamer_if.master    strm,
  output logic                busy,
  output logic [15:0]         block_cnt,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
`ifdef STREAM_CHECKSUM_EN
    S_SUM    = 2'd2,
`endif
    S_CLEAR  = 2'd3
  } state_t;

  localparam logic [ADDR_WID-1:0] LAST_PTR = ADDR_WID'(LEN - 1);

  state_t              state_q, state_d;
  logic [ADDR_WID-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]         block_cnt_q, block_cnt_d;
`ifdef STREAM_CHECKSUM_EN
  logic [WID-1:0]      sum_q, sum_d;
`endif

  logic                valid_w;
  logic                last_w;
  logic                clear_w;
  logic [WID-1:0]      data_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      block_cnt_q <= '0;
`ifdef STREAM_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      block_cnt_q <= block_cnt_d;
`ifdef STREAM_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Every output is decoded from state and registers only; out_ready steers
  // next-state logic but never reaches out_valid/out_data in the same cycle.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    block_cnt_d = block_cnt_q;
`ifdef STREAM_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    valid_w     = 1'b0;
    last_w      = 1'b0;
    clear_w     = 1'b0;
    data_w      = '0;

    case (state_q)
      S_IDLE: begin
        rd_ptr_d = '0;
`ifdef STREAM_CHECKSUM_EN
        sum_d    = '0;
`endif
        if (!buf_ready) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        valid_w = 1'b1;
        data_w  = buf_data;
`ifndef STREAM_CHECKSUM_EN
        last_w  = (rd_ptr_q == LAST_PTR);
`endif
        // valid is always high here, so out_ready alone marks a handshake
        if (strm.out_ready) begin
`ifdef STREAM_CHECKSUM_EN
          sum_d = sum_q + buf_data;
`endif
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
`ifdef STREAM_CHECKSUM_EN
            state_d  = S_SUM;
`else
            state_d  = S_CLEAR;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

`ifdef STREAM_CHECKSUM_EN
      S_SUM: begin
        valid_w = 1'b1;
        last_w  = 1'b1;
        data_w  = sum_q;
        if (strm.out_ready) begin
          state_d = S_CLEAR;
        end
      end
`endif

      S_CLEAR: begin
        // The buffer clears on the same edge that leaves this state, so
        // buf_ready is already high in the following IDLE cycle.
        clear_w     = 1'b1;
        block_cnt_d = block_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign strm.out_valid = valid_w;
  assign strm.out_last  = last_w;
  assign strm.out_data  = data_w;
  assign rd_ptr         = rd_ptr_q;
  assign buf_clear      = clear_w;
  assign busy           = (state_q != S_IDLE);
  assign block_cnt      = block_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_block_streamer.sv
// ---------------------------------------------------------------------------
// tb_block_streamer
//   Bench for block_streamer. A simple block-buffer model feeds buf_data and
//   buf_ready; a scoreboard queue holds the words each loaded block must
//   produce ({last, read address, data}). One compare process checks the DUT
//   against that queue on every falling clock edge; directed tests add
//   hand-computed literal expectations for timing and block counts.
//   Build with +define+STREAM_CHECKSUM_EN to cover the checksum word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_block_streamer;
  localparam int LEN = 8;
  localparam int WID = 8;
  localparam int AW  = 3;
`ifdef STREAM_CHECKSUM_EN
  localparam bit             CSUM    = 1'b1;
  localparam int             NW      = LEN + 1;
  localparam logic [WID-1:0] LASTW_A = 8'h01;  // FF+02 mod 256
  localparam logic [WID-1:0] LASTW_B = 8'h9C;  // 0x10+..+0x17 = 0x9C
`else
  localparam bit             CSUM    = 1'b0;
  localparam int             NW      = LEN;
  localparam logic [WID-1:0] LASTW_A = 8'h00;
  localparam logic [WID-1:0] LASTW_B = 8'h17;
`endif
  localparam logic [LEN*WID-1:0] BLK_B = 64'h1716_1514_1312_1110;
  localparam logic [LEN*WID-1:0] BLK_A = 64'h0000_0000_0000_02FF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT and buffer model ----------------
  logic           buf_ready;
  logic [WID-1:0] buf_data;
  logic [AW-1:0]  rd_ptr;
  logic           buf_clear;
  logic           busy;
  logic [15:0]    block_cnt;
  logic [1:0]     dbg_state;
  logic [WID-1:0] mem [LEN];
  logic           buf_full;

  block_streamer_if #(.WID(WID)) sif ();

  block_streamer #(.LEN(LEN), .WID(WID)) dut (
    .clk       (clk),
    .reset     (reset),
    .buf_ready (buf_ready),
    .buf_data  (buf_data),
    .rd_ptr    (rd_ptr),
    .buf_clear (buf_clear),
    .strm      (sif.master),
    .busy      (busy),
    .block_cnt (block_cnt),
    .dbg_state (dbg_state)
  );

  assign buf_ready = ~buf_full;
  assign buf_data  = mem[rd_ptr];

  // ---------------- scoreboard ----------------
  logic [WID+AW:0] exp_q [$];   // {last, rd_ptr, data}
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observation state kept by the compare process
  int             cyc = 0;
  int             blocks_model = 0;
  bit             exp_clear = 1'b0;
  int             vcnt = 0;
  int             hs_in_blk = 0;
  int             blk_vcycles = 0;
  int             blk_hs = 0;
  int             clear_pulses = 0;
  int             clear_cyc = 0;
  int             first_valid_cyc = 0;
  int             last_hs_cyc = 0;
  logic [WID-1:0] first_word = '0;
  logic [WID-1:0] last_word = '0;
  bit             prev_stall = 1'b0;
  logic [WID-1:0] prev_data = '0;

  always @(negedge clk) begin
    logic [WID+AW:0] e;
    cyc++;
    if (reset !== 1'b0) begin
      blocks_model = 0;
      exp_clear    = 1'b0;
      vcnt         = 0;
      hs_in_blk    = 0;
      prev_stall   = 1'b0;
    end else begin
      if (buf_clear === 1'b1) clear_pulses++;
      check("buf_clear", buf_clear, exp_clear);
      check("block_cnt", block_cnt, blocks_model[15:0]);
      check("busy", busy, sif.out_valid | exp_clear);
      if (exp_clear) begin
        blocks_model++;
        clear_cyc   = cyc;
        blk_vcycles = vcnt;
        blk_hs      = hs_in_blk;
        vcnt        = 0;
        hs_in_blk   = 0;
      end
      exp_clear = 1'b0;
      if (sif.out_valid === 1'b1) begin
        if (vcnt == 0) begin
          first_valid_cyc = cyc;
          first_word      = sif.out_data;
        end
        vcnt++;
        if (prev_stall) check("stall_hold", sif.out_data, prev_data);
        if (exp_q.size() == 0) begin
          check("valid_unexp", sif.out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          check("data", sif.out_data, e[WID-1:0]);
          check("last", sif.out_last, e[WID+AW]);
          check("rd_ptr", rd_ptr, e[WID+AW-1:WID]);
          if (sif.out_ready === 1'b1) begin
            void'(exp_q.pop_front());
            hs_in_blk++;
            last_word   = sif.out_data;
            last_hs_cyc = cyc;
            if (e[WID+AW]) exp_clear = 1'b1;
          end
        end
        prev_stall = (sif.out_ready !== 1'b1);
        prev_data  = sif.out_data;
      end else begin
        check("idle_data", sif.out_data, '0);
        check("idle_last", sif.out_last, 1'b0);
        check("idle_rd_ptr", rd_ptr, '0);
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock per call; applies a buffer clear seen in the cycle just ended.
  task automatic step();
    logic clr;
    @(negedge clk);
    clr = buf_clear;
    @(posedge clk);
    #1;
    if (clr === 1'b1) buf_full = 1'b0;
  endtask

  task automatic push_exp(input logic [LEN*WID-1:0] v);
    logic [WID-1:0] s;
    s = '0;
    for (int i = 0; i < LEN; i++) begin
      s = s + v[i*WID +: WID];
      exp_q.push_back({(CSUM == 1'b0) && (i == LEN - 1), AW'(i), v[i*WID +: WID]});
    end
    if (CSUM) exp_q.push_back({1'b1, AW'(0), s});
  endtask

  task automatic fill(input logic [LEN*WID-1:0] v);
    for (int i = 0; i < LEN; i++) mem[i] = v[i*WID +: WID];
    push_exp(v);
    buf_full = 1'b1;
  endtask

  task automatic wait_blocks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (clear_pulses < target && n < budget) begin
      step();
      n++;
    end
    check(name, clear_pulses, target);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c1;
    int n;
    logic [WID-1:0] lw1;
    reset         = 1'b1;
    buf_full      = 1'b0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) mem[i] = '0;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;

    // T1: idle with an empty buffer
    repeat (20) step();
    check("t1_valid", sif.out_valid, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_rd_ptr", rd_ptr, '0);
    check("t1_clears", clear_pulses, 0);
    check("t1_block_cnt", block_cnt, 16'd0);
    check("t1_state", dbg_state, 2'd0);

    // T2: full-rate block
    sif.out_ready = 1'b1;
    fill(BLK_B);
    wait_blocks(1, 40, "t2_done");
    check("t2_block_cnt", block_cnt, 16'd1);
    check("t2_words", blk_hs, NW);
    check("t2_vcycles", blk_vcycles, NW);
    check("t2_first", first_word, 8'h10);
    check("t2_last", last_word, LASTW_B);
    check("t2_clear_gap", clear_cyc - last_hs_cyc, 1);

    // T3: out_ready low on every other cycle, starting low
    sif.out_ready = 1'b0;
    fill(BLK_B);
    step();
    n = 0;
    while (clear_pulses < 2 && n < 80) begin
      step();
      sif.out_ready = ~sif.out_ready;
      n++;
    end
    check("t3_done", clear_pulses, 2);
    check("t3_block_cnt", block_cnt, 16'd2);
    check("t3_words", blk_hs, NW);
    check("t3_vcycles", blk_vcycles, 2 * NW);
    check("t3_last", last_word, LASTW_B);

    // T4: reset after word 3 with the buffer still full
    sif.out_ready = 1'b1;
    fill(BLK_B);
    n = 0;
    while (hs_in_blk < 4 && n < 20) begin
      step();
      n++;
    end
    check("t4_reach_w3", hs_in_blk, 4);
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    push_exp(BLK_B);
    check("t4_no_clear", clear_pulses, 2);
    check("t4_cnt_reset", block_cnt, 16'd0);
    wait_blocks(3, 40, "t4_done");
    check("t4_restart", first_word, 8'h10);
    check("t4_block_cnt", block_cnt, 16'd1);

    // T5: two back-to-back blocks from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    fill(BLK_A);
    wait_blocks(4, 40, "t5_blk1");
    c1  = clear_cyc;
    lw1 = last_word;
    fill(BLK_B);
    wait_blocks(5, 40, "t5_blk2");
    check("t5_blk1_last", lw1, LASTW_A);
    check("t5_blk2_last", last_word, LASTW_B);
    check("t5_idle_gap", first_valid_cyc - c1, 2);
    check("t5_block_cnt", block_cnt, 16'd2);
    repeat (3) step();
    check("t5_drained", exp_q.size(), 0);
    check("t5_idle_valid", sif.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
